// File: rtl/sprite_pkg.sv
// Shared sprite-sheet geometry, jump FSM state type and frame-index mapping.
// Also used by the rom/palette wrappers.
package sprite_pkg;

  localparam int unsigned SPR_W    = 64;
  localparam int unsigned SPR_H    = 64;
  localparam int unsigned N_FRAMES = 4;

  localparam int unsigned SPR_W_LG = $clog2(SPR_W);
  localparam int unsigned SPR_H_LG = $clog2(SPR_H);
  localparam int unsigned FRAME_W  = $clog2(N_FRAMES);
  localparam int unsigned ADDR_W   = FRAME_W + SPR_W_LG + SPR_H_LG;

  typedef enum logic [1:0] {GROUND, RISE, FALL, LAND} jump_state_t;

  function automatic logic [FRAME_W-1:0] frame_index(input jump_state_t state);
    logic [FRAME_W-1:0] idx;
    unique case (state)
      GROUND:  idx = FRAME_W'(0);
      RISE:    idx = FRAME_W'(1);
      FALL:    idx = FRAME_W'(2);
      LAND:    idx = FRAME_W'(3);
      default: idx = FRAME_W'(0);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Beam-vs-sprite hit test; registers the sprite ROM address and sprite_on with 1-cycle latency.
module sprite_addr_gen
  import sprite_pkg::*;
(
  input  logic                vga_clk_i,
  input  logic                reset_i,
  input  logic [9:0]          pos_x_i,
  input  logic [9:0]          pos_y_i,
  input  logic [FRAME_W-1:0]  frame_i,
  input  logic [9:0]          draw_x_i,
  input  logic [9:0]          draw_y_i,
  output logic [ADDR_W-1:0]   rom_address_o,
  output logic                sprite_on_o
);

  logic [10:0]       draw_x_ext, draw_y_ext, pos_x_ext, pos_y_ext;
  logic [10:0]       dx, dy;
  logic              hit_x, hit_y, hit;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] rom_address_q;
  logic              sprite_on_q;

  // 11-bit compares so pos + SPR_W cannot wrap at the right/bottom edge.
  always_comb begin
    draw_x_ext = {1'b0, draw_x_i};
    draw_y_ext = {1'b0, draw_y_i};
    pos_x_ext  = {1'b0, pos_x_i};
    pos_y_ext  = {1'b0, pos_y_i};
    dx         = draw_x_ext - pos_x_ext;
    dy         = draw_y_ext - pos_y_ext;
    hit_x      = (draw_x_ext >= pos_x_ext) && (draw_x_ext < pos_x_ext + 11'(SPR_W));
    hit_y      = (draw_y_ext >= pos_y_ext) && (draw_y_ext < pos_y_ext + 11'(SPR_H));
    hit        = hit_x && hit_y;
    addr       = (ADDR_W'(frame_i) << (SPR_W_LG + SPR_H_LG))
               + (ADDR_W'(dy) << SPR_W_LG)
               + ADDR_W'(dx);
  end

  always_ff @(posedge vga_clk_i) begin
    if (reset_i) begin
      rom_address_q <= '0;
      sprite_on_q   <= 1'b0;
    end else begin
      rom_address_q <= hit ? addr : '0;
      sprite_on_q   <= hit;
    end
  end

  assign rom_address_o = rom_address_q;
  assign sprite_on_o   = sprite_on_q;

endmodule

// File: rtl/sprite_jump_animator.sv
// Fighter sprite position and jump FSM, updated once per frame on frame_start,
// feeding the sprite ROM address generator.
module sprite_jump_animator
  import sprite_pkg::*;
#(
  parameter int unsigned GROUND_Y = 400,
  parameter int unsigned X_MIN    = 0,
  parameter int unsigned X_MAX    = 576,
  parameter int unsigned X_INIT   = 288,
  parameter int unsigned STEP_X   = 2,
  parameter int unsigned JUMP_V0  = 12,
  parameter int unsigned GRAVITY  = 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_jump,
  output logic [ADDR_W-1:0] rom_address,
  output logic              sprite_on,
  output logic [9:0]        pos_x,
  output logic [9:0]        pos_y,
  output logic              jumping
);

  localparam logic signed [10:0] GroundYS = 11'(GROUND_Y);
  localparam logic signed [10:0] XMinS    = 11'(X_MIN);
  localparam logic signed [10:0] XMaxS    = 11'(X_MAX);
  localparam logic signed [10:0] StepXS   = 11'(STEP_X);
  localparam logic signed [10:0] JumpV0S  = 11'(JUMP_V0);
  localparam logic signed [10:0] GravityS = 11'(GRAVITY);

  jump_state_t        state_q, state_d;
  logic [9:0]         pos_x_q, pos_x_d;
  logic [9:0]         pos_y_q, pos_y_d;
  logic signed [10:0] vel_q, vel_d;
  logic               jumping_q;

  logic signed [10:0] x_calc, y_calc, v_calc;

  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    vel_d   = vel_q;
    y_calc  = '0;
    v_calc  = '0;

    // Horizontal move with saturation, independent of jump state.
    x_calc = signed'({1'b0, pos_x_q});
    if (btn_left && !btn_right) begin
      x_calc = x_calc - StepXS;
    end else if (btn_right && !btn_left) begin
      x_calc = x_calc + StepXS;
    end
    if (x_calc < XMinS) begin
      pos_x_d = XMinS[9:0];
    end else if (x_calc > XMaxS) begin
      pos_x_d = XMaxS[9:0];
    end else begin
      pos_x_d = x_calc[9:0];
    end

    unique case (state_q)
      GROUND: begin
        if (btn_jump) begin
          vel_d   = JumpV0S;
          state_d = RISE;
        end
      end
      RISE: begin
        y_calc  = signed'({1'b0, pos_y_q}) - vel_q;
        pos_y_d = y_calc[10] ? 10'd0 : y_calc[9:0];
        v_calc  = vel_q - GravityS;
        if (v_calc <= 0) begin
          vel_d   = '0;
          state_d = FALL;
        end else begin
          vel_d = v_calc;
        end
      end
      FALL: begin
        v_calc = vel_q + GravityS;
        y_calc = signed'({1'b0, pos_y_q}) + v_calc;
        if (y_calc >= GroundYS) begin
          pos_y_d = GroundYS[9:0];
          vel_d   = '0;
          state_d = LAND;
        end else begin
          pos_y_d = y_calc[9:0];
          vel_d   = v_calc;
        end
      end
      LAND: begin
        state_d = GROUND;
      end
      default: state_d = GROUND;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q   <= GROUND;
      pos_x_q   <= 10'(X_INIT);
      pos_y_q   <= 10'(GROUND_Y);
      vel_q     <= '0;
      jumping_q <= 1'b0;
    end else if (frame_start) begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      vel_q     <= vel_d;
      jumping_q <= (state_d == RISE) || (state_d == FALL);
    end
  end

  sprite_addr_gen u_addr_gen (
    .vga_clk_i     (vga_clk),
    .reset_i       (reset),
    .pos_x_i       (pos_x_q),
    .pos_y_i       (pos_y_q),
    .frame_i       (frame_index(state_q)),
    .draw_x_i      (DrawX),
    .draw_y_i      (DrawY),
    .rom_address_o (rom_address),
    .sprite_on_o   (sprite_on)
  );

  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;
  assign jumping = jumping_q;

endmodule

// File: tb/tb_sprite_jump_animator.sv
// Directed bench for sprite_jump_animator: reset, jump arc, horizontal saturation, ROM addressing.
module tb_sprite_jump_animator;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_jump = 1'b0;
  logic [13:0] rom_address;
  logic        sprite_on;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        jumping;

  int errors = 0;
  int checks = 0;

  int arc_y [24] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322,
                     323, 325, 328, 332, 337, 343, 350, 358, 367, 377, 388, 400};

  sprite_jump_animator dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .frame_start (frame_start),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_jump    (btn_jump),
    .rom_address (rom_address),
    .sprite_on   (sprite_on),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .jumping     (jumping)
  );

  always #20 vga_clk = ~vga_clk;

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic do_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int jump_cnt;
    int max_x;
    int min_x;

    // Reset held with frame_start and buttons active: reset must win.
    reset = 1'b1; frame_start = 1'b1; btn_jump = 1'b1; btn_right = 1'b1;
    DrawX = 10'd288; DrawY = 10'd400;
    repeat (3) tick();
    check("rst_pos_x", 32'(pos_x), 288);
    check("rst_pos_y", 32'(pos_y), 400);
    check("rst_jumping", 32'(jumping), 0);
    check("rst_sprite_on", 32'(sprite_on), 0);
    check("rst_rom_addr", 32'(rom_address), 0);
    reset = 1'b0; frame_start = 1'b0; btn_jump = 1'b0;

    // Without frame_start nothing moves.
    repeat (5) tick();
    check("hold_pos_x", 32'(pos_x), 288);
    btn_right = 1'b0;

    // Address path with sprite at (288,400), GROUND frame 0.
    DrawX = 10'd288; DrawY = 10'd400; tick();
    check("addr_tl_on", 32'(sprite_on), 1);
    check("addr_tl", 32'(rom_address), 0);
    DrawX = 10'd351; DrawY = 10'd463; tick();
    check("addr_br_on", 32'(sprite_on), 1);
    check("addr_br", 32'(rom_address), 4095);
    DrawX = 10'd352; DrawY = 10'd400; tick();
    check("addr_right_off", 32'(sprite_on), 0);
    check("addr_right_zero", 32'(rom_address), 0);
    DrawX = 10'd287; DrawY = 10'd410; tick();
    check("addr_left_off", 32'(sprite_on), 0);
    DrawX = 10'd300; DrawY = 10'd464; tick();
    check("addr_bottom_off", 32'(sprite_on), 0);

    // Full jump: one GROUND frame with btn_jump, then 30 frames.
    btn_jump = 1'b1;
    do_frame();
    check("jump_start_y", 32'(pos_y), 400);
    check("jump_start_jumping", 32'(jumping), 1);
    jump_cnt = int'(jumping);
    btn_jump = 1'b0;
    for (int i = 0; i < 30; i++) begin
      do_frame();
      check($sformatf("arc_y_%0d", i), 32'(pos_y), (i < 24) ? 32'(arc_y[i]) : 32'd400);
      jump_cnt += int'(jumping);
    end
    check("jump_frames", 32'(jump_cnt), 24);
    check("after_jump_x", 32'(pos_x), 288);

    // Horizontal: one step, then saturation right and left.
    btn_right = 1'b1;
    do_frame();
    check("step_right", 32'(pos_x), 290);
    max_x = 0;
    for (int i = 0; i < 300; i++) begin
      do_frame();
      if (int'(pos_x) > max_x) max_x = int'(pos_x);
    end
    check("sat_right_max", 32'(max_x), 576);
    check("sat_right_x", 32'(pos_x), 576);
    btn_left = 1'b1;
    repeat (4) do_frame();
    check("both_hold", 32'(pos_x), 576);
    btn_right = 1'b0;
    min_x = 1023;
    for (int i = 0; i < 300; i++) begin
      do_frame();
      if (int'(pos_x) < min_x) min_x = int'(pos_x);
    end
    check("sat_left_min", 32'(min_x), 0);
    check("sat_left_x", 32'(pos_x), 0);
    btn_left = 1'b0;

    // Back to (288,400), jump and stop after 6 RISE frames.
    reset = 1'b1; tick(); reset = 1'b0;
    btn_jump = 1'b1; do_frame(); btn_jump = 1'b0;
    repeat (6) do_frame();
    check("mid_rise_y", 32'(pos_y), 343);
    check("mid_rise_jumping", 32'(jumping), 1);
    DrawX = 10'd290; DrawY = 10'd353; tick();
    check("rise_addr_on", 32'(sprite_on), 1);
    check("rise_addr", 32'(rom_address), 4738);

    // Reset mid-jump lands immediately, without a frame_start.
    reset = 1'b1; tick(); reset = 1'b0;
    check("midjump_rst_y", 32'(pos_y), 400);
    check("midjump_rst_jumping", 32'(jumping), 0);

    // btn_jump held throughout: LAND ignores it, next GROUND frame starts a new jump.
    btn_jump = 1'b1;
    do_frame();
    repeat (24) do_frame();
    check("land_y", 32'(pos_y), 400);
    check("land_jumping", 32'(jumping), 0);
    do_frame();
    check("land_ignores_jump", 32'(jumping), 0);
    do_frame();
    check("rejump_jumping", 32'(jumping), 1);
    check("rejump_y", 32'(pos_y), 400);
    do_frame();
    check("rejump_first_rise", 32'(pos_y), 388);
    btn_jump = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
